// File: rtl/cv32e40p_fetch_supply_buffer_pkg.sv
// Shared types and helpers for the instruction fetch supply buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cv32e40p_fetch_supply_buffer_pkg;

  // Step between consecutive sequential fetch addresses (one 32-bit word).
  localparam logic [31:0] FETCH_STRIDE = 32'd4;

  // OBI request side of the prefetcher. ISSUE and WAIT_GNT both drive a request;
  // WAIT_GNT marks a request that has already been presented and must be held.
  typedef enum logic [1:0] {
    PF_IDLE     = 2'd0,
    PF_ISSUE    = 2'd1,
    PF_WAIT_GNT = 2'd2
  } prefetch_state_e;

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cv32e40p_fetch_supply_buffer_if.sv
// OBI instruction port bundle between the prefetcher (master) and memory (slave).
// Latency: n/a (wires only).
// Backpressure: request/address held by the master until gnt; rvalid is not backpressured.
interface cv32e40p_fetch_supply_buffer_if;

  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_gnt,
    input  instr_rvalid,
    input  instr_rdata
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_gnt,
    output instr_rvalid,
    output instr_rdata
  );

endinterface

// File: rtl/cv32e40p_fetch_supply_buffer_fifo.sv
// Small word FIFO holding fetched instructions, with a synchronous flush.
// Latency: a push is visible on count_o/head_data_o the following cycle.
// Backpressure: none internally; the caller must never push when full without popping.
module cv32e40p_fetch_supply_buffer_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [31:0]      push_data_i,
  input  logic             pop_i,
  output logic [31:0]      head_data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointer/count; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only observed when count_o is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && !flush_i && (cnt_q == FULL_CNT)));

endmodule

// File: rtl/cv32e40p_fetch_supply_buffer.sv
// Prefetcher: issues OBI fetches, buffers returned words, flushes and redirects on branch.
// Latency: fetch_valid_o rises one cycle after the rvalid that delivers the word.
// Backpressure: stops issuing when buffered + in-flight words reach DEPTH; IF stage pops on fetch_ready_i.
module cv32e40p_fetch_supply_buffer
  import cv32e40p_fetch_supply_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_req_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_ready_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  output logic        busy_o,
  cv32e40p_fetch_supply_buffer_if.master obi_m
);

  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned      SUM_W   = CNT_W + 2;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

  prefetch_state_e  state_q, state_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      stale_addr_q, stale_addr_d;
  logic             stale_q, stale_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [SUM_W-1:0] outstanding_w, discard_w, inflight_next;
  logic [CNT_W-1:0] fifo_cnt, fifo_cnt_next;
  logic [31:0]      branch_tgt;
  logic             instr_req;
  logic             gnt_acc, rvalid_keep, rvalid_drop;
  logic             push, pop, credit;

  assign branch_tgt  = word_align(branch_addr_i);
  assign gnt_acc     = instr_req & obi_m.instr_gnt;
  // Responses belonging to flushed requests arrive first (in-order OBI), so they
  // are recognised simply by a non-zero discard count.
  assign rvalid_drop = obi_m.instr_rvalid & (discard_q != '0);
  assign rvalid_keep = obi_m.instr_rvalid & (discard_q == '0);
  assign push        = rvalid_keep & ~branch_req_i;
  assign pop         = fetch_valid_o & fetch_ready_i & ~branch_req_i;

  // Outstanding/discard bookkeeping; a branch moves every live transaction to discard.
  always_comb begin
    outstanding_w = SUM_W'(outstanding_q);
    discard_w     = SUM_W'(discard_q);
    if (branch_req_i) begin
      discard_w     = discard_w + outstanding_w + SUM_W'(gnt_acc)
                      - SUM_W'(obi_m.instr_rvalid);
      outstanding_w = '0;
    end else begin
      discard_w     = discard_w + SUM_W'(gnt_acc & stale_q) - SUM_W'(rvalid_drop);
      outstanding_w = outstanding_w + SUM_W'(gnt_acc & ~stale_q) - SUM_W'(rvalid_keep);
    end
    outstanding_d = outstanding_w[CNT_W-1:0];
    discard_d     = discard_w[CNT_W-1:0];
  end

  // Credit looks at next-cycle totals so a granted request is already counted.
  always_comb begin
    fifo_cnt_next = branch_req_i ? '0 : fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    inflight_next = SUM_W'(fifo_cnt_next) + SUM_W'(outstanding_d) + SUM_W'(discard_d);
    credit        = inflight_next < DEPTH_S;
  end

  // Fetch address: a branch hitting an ungranted request is parked until that grant.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    stale_d      = stale_q;
    stale_addr_d = stale_addr_q;
    if (gnt_acc) begin
      fetch_addr_d = stale_q ? stale_addr_q : fetch_addr_q + FETCH_STRIDE;
      stale_d      = 1'b0;
    end
    if (branch_req_i) begin
      if (instr_req && !obi_m.instr_gnt) begin
        stale_d      = 1'b1;
        stale_addr_d = branch_tgt;
      end else begin
        fetch_addr_d = branch_tgt;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= PF_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: an ungranted request is always held regardless of req_i/branch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PF_IDLE: begin
        if (req_i && credit) state_d = PF_ISSUE;
      end
      PF_ISSUE, PF_WAIT_GNT: begin
        if (obi_m.instr_gnt) state_d = (req_i && credit) ? PF_ISSUE : PF_IDLE;
        else                 state_d = PF_WAIT_GNT;
      end
      default: state_d = PF_IDLE;
    endcase
  end

  // FSM outputs: request while issuing or holding; address is stable until granted.
  always_comb begin
    instr_req = (state_q == PF_ISSUE) || (state_q == PF_WAIT_GNT);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_addr_q  <= RESET_ADDR;
      stale_addr_q  <= RESET_ADDR;
      stale_q       <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      stale_addr_q  <= stale_addr_d;
      stale_q       <= stale_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  cv32e40p_fetch_supply_buffer_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (branch_req_i),
    .push_i      (push),
    .push_data_i (obi_m.instr_rdata),
    .pop_i       (pop),
    .head_data_o (fetch_rdata_o),
    .count_o     (fifo_cnt)
  );

  assign fetch_valid_o    = (fifo_cnt != '0);
  assign busy_o           = (outstanding_q != '0) || instr_req;
  assign obi_m.instr_req  = instr_req;
  assign obi_m.instr_addr = fetch_addr_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (SUM_W'(outstanding_q) + SUM_W'(discard_q) + SUM_W'(fifo_cnt)) <= DEPTH_S);

endmodule
